// File: rtl/accum_sched.sv
// Sample scheduler for the accumulate-and-average datapath: generates a periodic tick,
// sweeps enabled channels with one valid/ready request each, and tags window first/last samples.
module accum_sched #(
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2,
    parameter int WIN_LOG2 = 4,
    parameter int INT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [INT_W-1:0]  interval,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              ovr_clr,
    output logic              smp_valid,
    output logic [CH_W-1:0]   smp_ch,
    output logic              smp_first,
    output logic              smp_last,
    input  logic              smp_ready,
    output logic              busy,
    output logic              overrun
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]          state_reg;
    logic [INT_W-1:0]    tcnt_reg;
    logic [NUM_CH-1:0]   smask_reg;
    logic [WIN_LOG2-1:0] k_reg;
    logic                smp_valid_reg;
    logic [CH_W-1:0]     smp_ch_reg;
    logic                smp_first_reg;
    logic                smp_last_reg;
    logic                busy_reg;
    logic                overrun_reg;

    logic                tick;
    logic                hs;
    logic                final_hs;
    logic                start_new;
    logic                set_ovr;
    logic [NUM_CH-1:0]   above;
    logic [WIN_LOG2-1:0] k_cur;

    function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CH_W'(i);
            end
        end
        return idx;
    endfunction

    // Channels of the latched sweep mask still waiting behind the current one.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_above
        assign above[gi] = smask_reg[gi] && (gi > int'(smp_ch_reg));
    end

    assign tick      = enable && (tcnt_reg == interval);
    assign hs        = (state_reg == ST_ISSUE) && smp_ready;
    assign final_hs  = hs && !(|above);
    // Window index seen by a sweep starting this cycle (already advanced on a back-to-back start).
    assign k_cur     = final_hs ? k_reg + 1'b1 : k_reg;
    assign start_new = tick && (ch_mask != '0) && ((state_reg == ST_IDLE) || final_hs);
    assign set_ovr   = (state_reg == ST_ISSUE) && tick && !final_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            tcnt_reg      <= '0;
            smask_reg     <= '0;
            k_reg         <= '0;
            smp_valid_reg <= 1'b0;
            smp_ch_reg    <= '0;
            smp_first_reg <= 1'b0;
            smp_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (!enable) begin
                tcnt_reg <= '0;
            end else if (tcnt_reg == interval) begin
                tcnt_reg <= '0;
            end else begin
                tcnt_reg <= tcnt_reg + 1'b1;
            end

            if ((state_reg == ST_IDLE) && !enable) begin
                k_reg <= '0;
            end else if (final_hs) begin
                k_reg <= k_reg + 1'b1;
            end

            if (start_new) begin
                state_reg     <= ST_ISSUE;
                smask_reg     <= ch_mask;
                smp_ch_reg    <= lowest_set(ch_mask);
                smp_first_reg <= (k_cur == '0);
                smp_last_reg  <= (&k_cur);
                smp_valid_reg <= 1'b1;
                busy_reg      <= 1'b1;
            end else if (final_hs) begin
                state_reg     <= ST_IDLE;
                smp_valid_reg <= 1'b0;
                busy_reg      <= 1'b0;
            end else if (hs) begin
                smp_ch_reg <= lowest_set(above);
            end

            if (set_ovr) begin
                overrun_reg <= 1'b1;
            end else if (ovr_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign smp_valid = smp_valid_reg;
    assign smp_ch    = smp_ch_reg;
    assign smp_first = smp_first_reg;
    assign smp_last  = smp_last_reg;
    assign busy      = busy_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_accum_sched.sv
// Bench for accum_sched: directed scenarios plus random segments, checked by a scoreboard
// fed from a transaction-level reference model.
module tb_accum_sched;

    localparam int NUM_CH   = 4;
    localparam int CH_W     = 2;
    localparam int WIN_LOG2 = 2;
    localparam int INT_W    = 16;
    localparam int WIN      = 1 << WIN_LOG2;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [INT_W-1:0]  interval;
    logic [NUM_CH-1:0] ch_mask;
    logic              ovr_clr;
    logic              smp_valid;
    logic [CH_W-1:0]   smp_ch;
    logic              smp_first;
    logic              smp_last;
    logic              smp_ready;
    logic              busy;
    logic              overrun;

    accum_sched #(
        .NUM_CH  (NUM_CH),
        .CH_W    (CH_W),
        .WIN_LOG2(WIN_LOG2),
        .INT_W   (INT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .interval (interval),
        .ch_mask  (ch_mask),
        .ovr_clr  (ovr_clr),
        .smp_valid(smp_valid),
        .smp_ch   (smp_ch),
        .smp_first(smp_first),
        .smp_last (smp_last),
        .smp_ready(smp_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        bit first;
        bit last;
    } req_t;

    req_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    // Reference model state: tick counter, window sample count, requests left in sweep.
    logic [INT_W-1:0] m_tcnt = '0;
    int               m_k = 0;
    int               m_left = 0;
    bit               m_active = 0;
    bit               m_ovr = 0;
    bit               m_rst_seen = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic start_sweep();
        req_t r;
        m_left = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_mask[c]) begin
                r.ch    = c;
                r.first = (m_k == 0);
                r.last  = (m_k == WIN - 1);
                exp_q.push_back(r);
                m_left++;
            end
        end
        m_active = 1;
    endtask

    task automatic model_step();
        bit tick;
        bit fin;
        bit set_o;
        if (rst) begin
            m_tcnt = '0; m_k = 0; m_left = 0; m_active = 0; m_ovr = 0;
            exp_q.delete();
            m_rst_seen = 1;
            return;
        end
        m_rst_seen = 0;
        tick   = enable && (m_tcnt == interval);
        m_tcnt = (!enable || tick) ? '0 : m_tcnt + 1'b1;
        fin    = 0;
        set_o  = 0;
        if (m_active) begin
            if (smp_ready) begin
                m_left--;
                if (m_left == 0) begin
                    fin = 1;
                    m_k = (m_k + 1) % WIN;
                end
            end
            if (tick && !fin) set_o = 1;
            if (fin) begin
                if (tick && ch_mask != 0) start_sweep();
                else m_active = 0;
            end
        end else begin
            if (!enable) m_k = 0;
            else if (tick && ch_mask != 0) start_sweep();
        end
        if (set_o) m_ovr = 1;
        else if (ovr_clr) m_ovr = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compares DUT outputs with the model and pops a request on each handshake.
    initial begin
        req_t r;
        forever begin
            @(negedge clk);
            check("smp_valid", int'(smp_valid), int'(m_active));
            check("busy", int'(busy), int'(m_active));
            check("overrun", int'(overrun), int'(m_ovr));
            if (m_rst_seen) begin
                check("rst_smp_ch", int'(smp_ch), 0);
                check("rst_smp_first", int'(smp_first), 0);
                check("rst_smp_last", int'(smp_last), 0);
            end
            if (m_active) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_nonempty", 0, 1);
                end else begin
                    r = exp_q[0];
                    check("smp_ch", int'(smp_ch), r.ch);
                    check("smp_first", int'(smp_first), int'(r.first));
                    check("smp_last", int'(smp_last), int'(r.last));
                    if (smp_ready) begin
                        void'(exp_q.pop_front());
                        $display("hs t=%0t ch=%0d first=%0d last=%0d", $time, r.ch, r.first, r.last);
                    end
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int  waited;
        bit  found;
        rst = 1'b1; enable = 1'b0; interval = '0; ch_mask = '0; ovr_clr = 1'b0; smp_ready = 1'b0;
        run(3);
        rst = 1'b0;

        // Full mask, period 8, ready always high.
        interval = 16'd7; ch_mask = 4'b1111; smp_ready = 1'b1; enable = 1'b1;
        run(40);
        check("no_overrun_p8", int'(overrun), 0);

        // Sparse mask: only channels 1 and 3.
        enable = 1'b0; run(6);
        interval = 16'd5; ch_mask = 4'b1010; enable = 1'b1;
        run(30);

        // Back-to-back sweeps, then ticks faster than sweeps.
        enable = 1'b0; run(6);
        interval = 16'd3; ch_mask = 4'b1111; enable = 1'b1;
        run(40);
        enable = 1'b0; run(6);
        interval = 16'd1; enable = 1'b1;
        run(20);
        check("overrun_set", int'(overrun), 1);
        enable = 1'b0; run(8);
        ovr_clr = 1'b1; run(1);
        ovr_clr = 1'b0; run(2);
        check("overrun_cleared", int'(overrun), 0);

        // Backpressure on channel 2 for five cycles.
        interval = 16'd12; ch_mask = 4'b1111; smp_ready = 1'b1; enable = 1'b1;
        found = 0;
        for (waited = 0; waited < 60 && !found; waited++) begin
            if (smp_valid && smp_ch == 2'd2) found = 1;
            else run(1);
        end
        check("found_ch2", int'(found), 1);
        smp_ready = 1'b0; run(5);
        smp_ready = 1'b1; run(10);

        // Single channel, window wrap, enable drop in idle.
        enable = 1'b0; run(8);
        interval = 16'd2; ch_mask = 4'b0001; enable = 1'b1;
        run(30);
        enable = 1'b0; run(4);
        enable = 1'b1; run(20);

        // Reset while a request is stalled.
        enable = 1'b0; run(8);
        interval = 16'd4; ch_mask = 4'b0110; smp_ready = 1'b0; enable = 1'b1;
        run(10);
        rst = 1'b1; run(1);
        rst = 1'b0; smp_ready = 1'b1;
        run(20);

        // Random segments.
        for (int seg = 0; seg < 30; seg++) begin
            enable = 1'b0; run(2);
            interval = INT_W'($urandom_range(0, 10));
            ch_mask  = NUM_CH'($urandom_range(0, 15));
            enable   = 1'b1;
            for (int c = 0; c < 60; c++) begin
                smp_ready = ($urandom_range(0, 3) != 0);
                ovr_clr   = ($urandom_range(0, 19) == 0);
                rst       = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 9) == 0) ch_mask = NUM_CH'($urandom_range(0, 15));
                run(1);
            end
            rst = 1'b0; ovr_clr = 1'b0;
        end

        run(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
